// File: rtl/f9pcap_egress_arb.sv
// Frame-granular round-robin arbiter: merges PORT_COUNT f9phdr-wrapped capture streams onto one
// udp_eth_send egress, holding each grant from first beat to last and counting forwarded frames.
module f9pcap_egress_arb #(
    parameter int unsigned PORT_COUNT = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
    localparam int unsigned PORT_IDX_WIDTH = $clog2(PORT_COUNT)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [PORT_COUNT-1:0]           s_valid_in,
    output logic [PORT_COUNT-1:0]           s_ready_out,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_data_in,
    input  logic [PORT_COUNT*KEEP_WIDTH-1:0] s_keep_in,
    input  logic [PORT_COUNT-1:0]           s_last_in,
    input  logic [PORT_COUNT*LEN_WIDTH-1:0] s_data_len_in,
    output logic                            m_valid_out,
    input  logic                            m_ready_in,
    output logic [DATA_WIDTH-1:0]           m_data_out,
    output logic [KEEP_WIDTH-1:0]           m_keep_out,
    output logic                            m_last_out,
    output logic [LEN_WIDTH-1:0]            m_data_len_out,
    output logic [PORT_IDX_WIDTH-1:0]       m_port_out,
    output logic                            busy_out,
    output logic [PORT_COUNT*CNT_WIDTH-1:0] frame_cnt_out
);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e                    state;
    logic [PORT_IDX_WIDTH-1:0] grant;
    logic [PORT_IDX_WIDTH-1:0] rr_ptr;
    logic [CNT_WIDTH-1:0]      frame_cnt [PORT_COUNT];

    logic [DATA_WIDTH-1:0] data_lane [PORT_COUNT];
    logic [KEEP_WIDTH-1:0] keep_lane [PORT_COUNT];
    logic [LEN_WIDTH-1:0]  len_lane  [PORT_COUNT];

    logic [PORT_IDX_WIDTH-1:0] winner;
    logic                      found;
    logic                      frame_end;

    for (genvar p = 0; p < PORT_COUNT; p++) begin : g_lane
        assign data_lane[p] = s_data_in[p*DATA_WIDTH +: DATA_WIDTH];
        assign keep_lane[p] = s_keep_in[p*KEEP_WIDTH +: KEEP_WIDTH];
        assign len_lane[p]  = s_data_len_in[p*LEN_WIDTH +: LEN_WIDTH];
        assign frame_cnt_out[p*CNT_WIDTH +: CNT_WIDTH] = frame_cnt[p];
    end

    // First requester at or after rr_ptr, wrapping, wins.
    always_comb begin
        logic [31:0]               idx;
        logic [PORT_IDX_WIDTH-1:0] sel;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        sel    = '0;
        for (int unsigned i = 0; i < PORT_COUNT; i++) begin
            idx = (32'(rr_ptr) + i) % PORT_COUNT;
            sel = PORT_IDX_WIDTH'(idx);
            if (!found && s_valid_in[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    // Data path is a pure mux on the registered grant; no beat storage.
    assign m_valid_out    = (state == StXfer) && s_valid_in[grant];
    assign m_data_out     = data_lane[grant];
    assign m_keep_out     = keep_lane[grant];
    assign m_last_out     = s_last_in[grant];
    assign m_data_len_out = len_lane[grant];
    assign m_port_out     = grant;
    assign busy_out       = (state == StXfer);
    assign frame_end      = m_valid_out && m_ready_in && m_last_out;

    always_comb begin
        s_ready_out = '0;
        if (state == StXfer) begin
            s_ready_out[grant] = m_ready_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= StIdle;
            grant  <= '0;
            rr_ptr <= '0;
            for (int p = 0; p < PORT_COUNT; p++) begin
                frame_cnt[p] <= '0;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (found) begin
                        grant <= winner;
                        state <= StXfer;
                    end
                end
                StXfer: begin
                    if (frame_end) begin
                        state  <= StIdle;
                        rr_ptr <= (grant == PORT_IDX_WIDTH'(PORT_COUNT - 1)) ? '0 : grant + 1'b1;
                        frame_cnt[grant] <= frame_cnt[grant] + CNT_WIDTH'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
